// File: rtl/arb_pkg.sv
// Shared constants, state encoding and index type for the 8-way round-robin arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package arb_pkg;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/gnt_dec8.sv
// 3-to-8 one-hot decoder with enable; all zeros when disabled.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module gnt_dec8
    import arb_pkg::*;
(
    input  logic         en,
    input  idx_t         idx,
    output logic [N-1:0] onehot
);

    // Decode the index into a single set bit, or nothing when no grant is active.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters; holds one owner until done, withdrawal or watchdog expiry.
// Latency: request to registered grant is one cycle; one idle bubble cycle after every release.
// Backpressure: an owner keeps the grant while its request stays high; other requests wait in IDLE.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam bit                WD_EN     = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : (MAX_HOLD - 1));

    state_t             state;
    state_t             state_nxt;
    idx_t               ptr;
    idx_t               ptr_nxt;
    logic [HOLD_W-1:0]  hold;
    logic [HOLD_W-1:0]  hold_nxt;

    idx_t               pick_idx;
    logic               pick_vld;
    logic               rel;
    logic               rel_to;

    idx_t               idx_nxt;
    logic               vld_nxt;
    logic               to_nxt;
    logic [N-1:0]       gnt_nxt;

    // Rotating priority search: lowest offset from ptr wins, so scan offsets high-to-low and let the last hit stand.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = ptr;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[ptr + idx_t'(k)]) begin
                pick_vld = 1'b1;
                pick_idx = ptr + idx_t'(k);
            end
        end
    end

    // Next-state logic; release causes are prioritised so done masks a coincident watchdog expiry.
    always_comb begin
        state_nxt = state;
        rel       = 1'b0;
        rel_to    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (done) begin
                    rel = 1'b1;
                end else if (!req[gnt_idx]) begin
                    rel = 1'b1;
                end else if (WD_EN && (hold == HOLD_LAST)) begin
                    rel    = 1'b1;
                    rel_to = 1'b1;
                end
                if (rel) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for the registered outputs, rotation pointer and hold counter.
    always_comb begin
        idx_nxt  = gnt_idx;
        vld_nxt  = 1'b0;
        to_nxt   = 1'b0;
        ptr_nxt  = ptr;
        hold_nxt = hold;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    idx_nxt  = pick_idx;
                    vld_nxt  = 1'b1;
                    hold_nxt = '0;
                end
            end
            BUSY: begin
                if (rel) begin
                    // Previous owner becomes lowest priority; index 7 wraps to 0 by width.
                    ptr_nxt = gnt_idx + 1'b1;
                    to_nxt  = rel_to;
                end else begin
                    vld_nxt  = 1'b1;
                    hold_nxt = hold + 1'b1;
                end
            end
            default: begin
                vld_nxt = 1'b0;
            end
        endcase
    end

    gnt_dec8 u_gnt_dec8 (
        .en     (vld_nxt),
        .idx    (idx_nxt),
        .onehot (gnt_nxt)
    );

    // State and output registers; reset dominates every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            hold      <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            hold      <= hold_nxt;
            gnt       <= gnt_nxt;
            gnt_idx   <= idx_nxt;
            gnt_valid <= vld_nxt;
            timeout   <= to_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed self-checking bench for rr_arbiter8.
// Latency: inputs driven 1ns after a rising edge, outputs checked 1ns after the following edge.
// Backpressure: not applicable; stimulus is a fixed linear sequence.
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int tests = 0;
    int fails = 0;

    rr_arbiter8 #(
        .MAX_HOLD (16),
        .HOLD_W   (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Safety net so the run always ends even if the clock stalls.
    initial begin
        #100000;
        $display("FAIL time_limit: simulation still running at 100000, required finish earlier");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Compare all outputs; the index is only meaningful while a grant is valid.
    task automatic chk_out(input string tag, input logic [7:0] eg, input logic ev,
                           input logic [2:0] ei, input logic et);
        chk({tag, ".gnt"}, gnt, eg);
        chk({tag, ".gnt_valid"}, {7'd0, gnt_valid}, {7'd0, ev});
        chk({tag, ".timeout"}, {7'd0, timeout}, {7'd0, et});
        if (ev) begin
            chk({tag, ".gnt_idx"}, {5'd0, gnt_idx}, {5'd0, ei});
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = 8'h00;
        done  = 1'b0;

        // Reset held two cycles, then idle with no requests.
        tick();
        chk_out("reset_c1", 8'h00, 1'b0, 3'd0, 1'b0);
        chk("reset_c1.gnt_idx", {5'd0, gnt_idx}, 8'h00);
        tick();
        chk_out("reset_c2", 8'h00, 1'b0, 3'd0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out($sformatf("idle_%0d", i), 8'h00, 1'b0, 3'd0, 1'b0);
        end

        // done while idle must not create a grant.
        done = 1'b1;
        tick();
        chk_out("done_in_idle", 8'h00, 1'b0, 3'd0, 1'b0);
        done = 1'b0;

        // Single request on bit 3, done in the third grant cycle.
        req = 8'h08;
        tick();
        chk_out("single_t1", 8'h08, 1'b1, 3'd3, 1'b0);
        tick();
        chk_out("single_t2", 8'h08, 1'b1, 3'd3, 1'b0);
        tick();
        chk_out("single_t3", 8'h08, 1'b1, 3'd3, 1'b0);
        done = 1'b1;
        req  = 8'h00;
        tick();
        chk_out("single_t4", 8'h00, 1'b0, 3'd0, 1'b0);
        done = 1'b0;

        // ptr is now 4: with bits 0 and 4 both requesting, 4 wins.
        req = 8'h11;
        tick();
        chk_out("ptr_after_single", 8'h10, 1'b1, 3'd4, 1'b0);
        done = 1'b1;
        req  = 8'h00;
        tick();
        chk_out("ptr_after_single_rel", 8'h00, 1'b0, 3'd0, 1'b0);
        done = 1'b0;

        // Fresh start for rotation: ptr back to 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_out("rot_reset", 8'h00, 1'b0, 3'd0, 1'b0);

        // All requesting; done in the second grant cycle of each grant.
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            logic [7:0] one;
            one = 8'h01 << (k % 8);
            tick();
            chk_out($sformatf("rot_%0d_g1", k), one, 1'b1, 3'(k % 8), 1'b0);
            tick();
            chk_out($sformatf("rot_%0d_g2", k), one, 1'b1, 3'(k % 8), 1'b0);
            done = 1'b1;
            tick();
            done = 1'b0;
            chk_out($sformatf("rot_%0d_bubble", k), 8'h00, 1'b0, 3'd0, 1'b0);
        end

        // Move ptr to 6 by granting and releasing index 5.
        req = 8'h20;
        tick();
        chk_out("to_ptr6_grant", 8'h20, 1'b1, 3'd5, 1'b0);
        done = 1'b1;
        req  = 8'h00;
        tick();
        done = 1'b0;
        chk_out("to_ptr6_rel", 8'h00, 1'b0, 3'd0, 1'b0);

        // Wrap and skip: ptr 6, req bits 0 and 2 -> 0 first, then 2.
        req = 8'h05;
        tick();
        chk_out("wrap_from6", 8'h01, 1'b1, 3'd0, 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk_out("wrap_rel", 8'h00, 1'b0, 3'd0, 1'b0);
        tick();
        chk_out("skip_to2", 8'h04, 1'b1, 3'd2, 1'b0);
        done = 1'b1;
        req  = 8'h00;
        tick();
        done = 1'b0;
        chk_out("skip_rel", 8'h00, 1'b0, 3'd0, 1'b0);

        // Watchdog: ptr 3, only bit 1 requests, never done -> 16 grant cycles then timeout pulse.
        req = 8'h02;
        tick();
        chk_out("wd_c1", 8'h02, 1'b1, 3'd1, 1'b0);
        for (int i = 2; i <= 16; i++) begin
            tick();
            chk_out($sformatf("wd_c%0d", i), 8'h02, 1'b1, 3'd1, 1'b0);
        end
        tick();
        chk_out("wd_timeout", 8'h00, 1'b0, 3'd0, 1'b1);

        // ptr now 2: bit 2 outranks bit 1; timeout must already be gone.
        req = 8'h06;
        tick();
        chk_out("after_wd", 8'h04, 1'b1, 3'd2, 1'b0);

        // Non-owner request changes do not disturb the grant.
        req = 8'h07;
        tick();
        chk_out("other_req_ignored", 8'h04, 1'b1, 3'd2, 1'b0);

        // Owner withdraws: release next cycle with no timeout.
        req = 8'h03;
        tick();
        chk_out("withdraw", 8'h00, 1'b0, 3'd0, 1'b0);
        tick();
        chk_out("after_withdraw", 8'h01, 1'b1, 3'd0, 1'b0);

        // Reset during BUSY: outputs drop, next arbitration restarts at 0 instead of 1.
        reset = 1'b1;
        tick();
        chk_out("reset_mid", 8'h00, 1'b0, 3'd0, 1'b0);
        chk("reset_mid.gnt_idx", {5'd0, gnt_idx}, 8'h00);
        reset = 1'b0;
        tick();
        chk_out("post_reset_from0", 8'h01, 1'b1, 3'd0, 1'b0);

        // done coincides with watchdog expiry in the 16th cycle: no timeout pulse.
        for (int i = 2; i <= 16; i++) begin
            tick();
            chk_out($sformatf("dwd_c%0d", i), 8'h01, 1'b1, 3'd0, 1'b0);
        end
        done = 1'b1;
        req  = 8'h00;
        tick();
        done = 1'b0;
        chk_out("done_vs_wd", 8'h00, 1'b0, 3'd0, 1'b0);
        tick();
        chk_out("final_idle", 8'h00, 1'b0, 3'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one datapath resource (for example, the register-file write port or the memory interface) among 8 requesters in the multi-cycle core.
- Latches one winner, drives a one-hot grant and a binary grant index, and holds the grant until the owner signals done, drops its request, or a hold watchdog expires.
- Priority rotates so the most recent owner has the lowest priority in the next arbitration.

Parameters:
- N, 8, number of requesters; fixed at 8 for this block.
- IDX_W, 3, width of the grant index (log2 N).
- MAX_HOLD, 16, maximum number of cycles one grant may be held; 0 disables the watchdog.
- HOLD_W, 5, hold counter width; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  8  request vector; bit i is requester i.
- done  input  1  the current owner finished its transfer; sampled only in BUSY.
- gnt  output  8  one-hot grant; all zeros when no grant is active.
- gnt_idx  output  3  binary index of the granted requester; valid only while gnt_valid is 1.
- gnt_valid  output  1  a grant is active.
- timeout  output  1  one-cycle pulse when the watchdog revokes a grant.

Behaviour:
- Reset (synchronous, active-high; wins over all other inputs):
  - state = IDLE, gnt = 8'h00, gnt_idx = 0, gnt_valid = 0, timeout = 0.
  - Rotation pointer ptr = 0, hold counter = 0.
- States: IDLE, BUSY. All outputs are registered.
- IDLE:
  - If req != 0, select the first set bit searching ptr, ptr+1, ... with wrap mod 8.
  - Next cycle: state = BUSY, gnt_idx = selected index, gnt = one-hot decode of that index, gnt_valid = 1, hold counter = 0.
  - If req == 0, stay in IDLE with all outputs zero.
  - Latency: req asserted in cycle T gives gnt_valid = 1 in cycle T+1.
- BUSY: each cycle, evaluate in this priority order.
  - (a) done = 1: release.
  - (b) req[gnt_idx] = 0: release. The request was withdrawn, so the transfer is abandoned.
  - (c) MAX_HOLD != 0 and hold counter == MAX_HOLD-1: release and assert timeout = 1 in the next cycle.
  - Otherwise increment the hold counter and keep the grant unchanged.
  - A simultaneous done and watchdog expiry counts as a normal release with no timeout pulse.
- Release:
  - Next cycle: state = IDLE, gnt = 0, gnt_valid = 0, gnt_idx holds its last value.
  - ptr = (gnt_idx + 1) mod 8, so index 7 wraps to 0.
  - This gives a mandatory one-cycle bubble between grants, so no two owners overlap.
- timeout is high for exactly one cycle: the first IDLE cycle after a watchdog release.
- Changes to req bits other than the owner's have no effect during BUSY.
- done asserted in IDLE is ignored.
- Reset asserted during BUSY drops the grant on the next edge; ptr returns to 0.
- Invariant: gnt == (gnt_valid ? 1 << gnt_idx : 0) in every cycle.

Decomposition:
- Shared package arb_pkg holds:
  - constants N = 8 and IDX_W = 3;
  - state encoding IDLE = 1'b0, BUSY = 1'b1;
  - the typedef for the grant index.
- One sub-module, gnt_dec8: a combinational 3-to-8 one-hot decoder that produces gnt from the next gnt_idx before the output register.
- The rotating priority search stays inline in rr_arbiter8.

Test Plan:
- Reset and idle: reset high for 2 cycles, then req = 8'h00 for 5 cycles -> gnt = 0, gnt_valid = 0, timeout = 0 throughout.
- Single request: req = 8'h08 at T, done = 1 at T+3 -> gnt = 8'h08 and gnt_idx = 3 from T+1 to T+3; gnt = 0 at T+4; ptr = 4.
- Rotation and fairness: req = 8'hFF held, done pulsed in the 2nd grant cycle of each grant -> grant order 0, 1, 2, ... 7, 0 with exactly one idle cycle between grants.
- Wrap and skip: ptr = 6, req = 8'h05 -> grant goes to index 0, then index 2 on the next arbitration.
- Watchdog: MAX_HOLD = 16, req = 8'h02 held, done never asserted -> gnt held for exactly 16 cycles, then gnt = 0 and timeout = 1 for one cycle; next grant goes to index 1 only if req[1] is still set and no higher-rotation requester is present.
- Withdrawal and reset mid-grant:
  - Owner drops req during BUSY -> release the next cycle with no timeout pulse.
  - reset during BUSY -> all outputs 0 on the next edge; the next arbitration starts from index 0.
